// File: rtl/pio_result_arbiter_if.sv
// Bundle between the result producers / host PIOs and pio_result_arbiter.
//   req_valid  : per-producer result-valid flags
//   req_data   : packed payloads, producer i at [i*DATA_W +: DATA_W]
//   req_ready  : one-hot acceptance pulse back to the producers
//   ack_toggle : host ack from an output PIO bit; each level change is one ack
//   pio_word   : tagged word to the PIO in_port
//   busy       : high while a word is held
// master = producers/host side, slave = arbiter side.
interface pio_result_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 24
) ();
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      ack_toggle;
   logic [31:0]               pio_word;
   logic                      busy;

   modport master (
      output req_valid, req_data, ack_toggle,
      input  req_ready, pio_word, busy
   );

   modport slave (
      input  req_valid, req_data, ack_toggle,
      output req_ready, pio_word, busy
   );
endinterface

// File: rtl/pio_result_arbiter.sv
// Round-robin arbiter that shares one read-only 32-bit PIO input between
// NUM_REQ result producers. The winner is latched into a hold register and
// presented as {valid, timeout_sticky, seq[1:0], id[3:0], payload[23:0]}
// until the host toggles its ack bit; a one-cycle gap with valid low then
// separates consecutive words.
// Ports:
//   clk      : system clock (same domain as both PIOs)
//   reset_n  : asynchronous active-low reset
//   bus      : pio_result_arbiter_if.slave (requests, ack, PIO word, busy)
// Optional feature: define PIO_RESULT_ARBITER_TIMEOUT_EN to drop an
// unacknowledged word after TIMEOUT_CYC hold cycles and flag it in bit 30.
module pio_result_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned DATA_W      = 24,
   parameter int unsigned TIMEOUT_CYC = 50000000
) (
   input logic                 clk,
   input logic                 reset_n,
   pio_result_arbiter_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = 26;

   // Reject configurations outside the supported range at elaboration.
   if (NUM_REQ < 2 || NUM_REQ > 16 || DATA_W < 1 || DATA_W > 24 ||
       TIMEOUT_CYC < 2 || TIMEOUT_CYC > (1 << CNT_W)) begin : g_param_err
      $error("pio_result_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_e;

   state_e             state_q, state_d;
   logic [31:0]        word_q, word_d;
   logic [NUM_REQ-1:0] ready_q, ready_d;
   logic               busy_q, busy_d;
   logic [1:0]         seq_q, seq_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic               ack_q;
   logic               ack_evt_c;
   logic               grant_c;
   logic [PTR_W-1:0]   gidx_c;
   logic [DATA_W-1:0]  pay_c;
   logic               sticky_c;

`ifdef PIO_RESULT_ARBITER_TIMEOUT_EN
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sticky_q, sticky_d;
   assign sticky_c = sticky_q;
`else
   assign sticky_c = 1'b0;
`endif

   assign ack_evt_c = bus.ack_toggle ^ ack_q;

   // Rotating priority search starting just after the last winner.
   always_comb begin
      logic [PTR_W:0] idx;
      grant_c = 1'b0;
      gidx_c  = '0;
      idx     = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
         if (idx >= (PTR_W+1)'(NUM_REQ)) begin
            idx = idx - (PTR_W+1)'(NUM_REQ);
         end
         if (!grant_c && bus.req_valid[PTR_W'(idx)]) begin
            grant_c = 1'b1;
            gidx_c  = PTR_W'(idx);
         end
      end
   end

   assign pay_c = bus.req_data[32'(gidx_c) * DATA_W +: DATA_W];

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state and datapath decode.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      ready_d = '0;
      busy_d  = busy_q;
      seq_d   = seq_q;
      ptr_d   = ptr_q;
`ifdef PIO_RESULT_ARBITER_TIMEOUT_EN
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (grant_c) begin
               seq_d           = seq_q + 2'd1;
               ready_d[gidx_c] = 1'b1;
               ptr_d           = gidx_c;
               word_d          = {1'b1, sticky_c, seq_d, 4'(gidx_c), 24'(pay_c)};
               busy_d          = 1'b1;
               state_d         = S_HOLD;
`ifdef PIO_RESULT_ARBITER_TIMEOUT_EN
               cnt_d           = '0;
`endif
            end
         end
         S_HOLD: begin
            if (ack_evt_c) begin
               word_d[31] = 1'b0;
               busy_d     = 1'b0;
               state_d    = S_GAP;
`ifdef PIO_RESULT_ARBITER_TIMEOUT_EN
               sticky_d   = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               word_d[31] = 1'b0;
               busy_d     = 1'b0;
               sticky_d   = 1'b1;
               state_d    = S_GAP;
            end else begin
               cnt_d      = cnt_q + CNT_W'(1);
`endif
            end
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Hold register, ack sampler and arbitration bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_q  <= '0;
         ready_q <= '0;
         busy_q  <= 1'b0;
         seq_q   <= '0;
         ptr_q   <= PTR_W'(NUM_REQ - 1);
         ack_q   <= 1'b0;
`ifdef PIO_RESULT_ARBITER_TIMEOUT_EN
         cnt_q    <= '0;
         sticky_q <= 1'b0;
`endif
      end else begin
         word_q  <= word_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         seq_q   <= seq_d;
         ptr_q   <= ptr_d;
         ack_q   <= bus.ack_toggle;
`ifdef PIO_RESULT_ARBITER_TIMEOUT_EN
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
`endif
      end
   end

   assign bus.pio_word  = word_q;
   assign bus.req_ready = ready_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_pio_result_arbiter.sv
// Directed table-driven bench for pio_result_arbiter (default build).
module tb_pio_result_arbiter;
   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned DATA_W  = 24;
   localparam int unsigned NV      = 33;

   typedef struct {
      logic [3:0]  valid;
      logic        ack;
      logic [31:0] word;
      logic [3:0]  ready;
      logic        busy;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[NV];

   always #5 clk = ~clk;

   pio_result_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

   pio_result_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [31:0] w, input logic [3:0] r, input logic b);
      check({tag, " pio_word"}, bus.pio_word, w);
      check({tag, " req_ready"}, 32'(bus.req_ready), 32'(r));
      check({tag, " busy"}, 32'(bus.busy), 32'(b));
   endtask

   initial begin
      // Per-cycle vectors: inputs applied before an edge, outputs expected after it.
      vecs[0]  = '{4'b0001, 1'b0, 32'h9000_0007, 4'b0001, 1'b1};
      vecs[1]  = '{4'b0000, 1'b0, 32'h9000_0007, 4'b0000, 1'b1};
      vecs[2]  = '{4'b0000, 1'b0, 32'h9000_0007, 4'b0000, 1'b1};
      vecs[3]  = '{4'b0000, 1'b1, 32'h1000_0007, 4'b0000, 1'b0};
      vecs[4]  = '{4'b0000, 1'b1, 32'h1000_0007, 4'b0000, 1'b0};
      vecs[5]  = '{4'b1111, 1'b1, 32'hA100_0111, 4'b0010, 1'b1};
      vecs[6]  = '{4'b1101, 1'b1, 32'hA100_0111, 4'b0000, 1'b1};
      vecs[7]  = '{4'b1101, 1'b0, 32'h2100_0111, 4'b0000, 1'b0};
      vecs[8]  = '{4'b1101, 1'b0, 32'h2100_0111, 4'b0000, 1'b0};
      vecs[9]  = '{4'b1101, 1'b0, 32'hB200_ABCD, 4'b0100, 1'b1};
      vecs[10] = '{4'b1001, 1'b0, 32'hB200_ABCD, 4'b0000, 1'b1};
      vecs[11] = '{4'b1001, 1'b1, 32'h3200_ABCD, 4'b0000, 1'b0};
      vecs[12] = '{4'b1001, 1'b1, 32'h3200_ABCD, 4'b0000, 1'b0};
      vecs[13] = '{4'b1001, 1'b1, 32'h8300_0333, 4'b1000, 1'b1};
      vecs[14] = '{4'b0001, 1'b1, 32'h8300_0333, 4'b0000, 1'b1};
      vecs[15] = '{4'b0001, 1'b0, 32'h0300_0333, 4'b0000, 1'b0};
      vecs[16] = '{4'b0001, 1'b0, 32'h0300_0333, 4'b0000, 1'b0};
      vecs[17] = '{4'b0001, 1'b0, 32'h9000_0007, 4'b0001, 1'b1};
      vecs[18] = '{4'b0000, 1'b0, 32'h9000_0007, 4'b0000, 1'b1};
      vecs[19] = '{4'b0000, 1'b1, 32'h1000_0007, 4'b0000, 1'b0};
      vecs[20] = '{4'b0000, 1'b0, 32'h1000_0007, 4'b0000, 1'b0};
      vecs[21] = '{4'b0000, 1'b1, 32'h1000_0007, 4'b0000, 1'b0};
      vecs[22] = '{4'b0100, 1'b1, 32'hA200_ABCD, 4'b0100, 1'b1};
      vecs[23] = '{4'b0000, 1'b1, 32'hA200_ABCD, 4'b0000, 1'b1};
      vecs[24] = '{4'b0000, 1'b1, 32'hA200_ABCD, 4'b0000, 1'b1};
      vecs[25] = '{4'b0000, 1'b0, 32'h2200_ABCD, 4'b0000, 1'b0};
      vecs[26] = '{4'b0000, 1'b0, 32'h2200_ABCD, 4'b0000, 1'b0};
      vecs[27] = '{4'b0001, 1'b0, 32'hB000_0007, 4'b0001, 1'b1};
      vecs[28] = '{4'b1000, 1'b0, 32'hB000_0007, 4'b0000, 1'b1};
      vecs[29] = '{4'b1000, 1'b1, 32'h3000_0007, 4'b0000, 1'b0};
      vecs[30] = '{4'b0000, 1'b1, 32'h3000_0007, 4'b0000, 1'b0};
      vecs[31] = '{4'b0000, 1'b1, 32'h3000_0007, 4'b0000, 1'b0};
      vecs[32] = '{4'b0010, 1'b1, 32'h8100_0111, 4'b0010, 1'b1};

      reset_n        = 1'b0;
      bus.req_valid  = '0;
      bus.ack_toggle = 1'b0;
      bus.req_data   = {24'h000333, 24'h00ABCD, 24'h000111, 24'h000007};
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check_outs("reset", 32'h0, 4'b0000, 1'b0);

      for (int i = 0; i < int'(NV); i++) begin
         @(negedge clk);
         bus.req_valid  = vecs[i].valid;
         bus.ack_toggle = vecs[i].ack;
         @(posedge clk); #1;
         check_outs($sformatf("vec%0d", i), vecs[i].word, vecs[i].ready, vecs[i].busy);
      end

      // Reset in the middle of a hold clears outputs without a clock edge.
      @(negedge clk);
      bus.req_valid = '0;
      reset_n       = 1'b0;
      #1;
      check_outs("async_reset", 32'h0, 4'b0000, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset_n       = 1'b1;
      bus.req_valid = 4'b1111;
      @(posedge clk); #1;
      check_outs("post_reset_grant", 32'h9000_0007, 4'b0001, 1'b1);
      @(negedge clk);
      bus.req_valid = 4'b1110;
      @(posedge clk); #1;
      check_outs("post_reset_hold", 32'h9000_0007, 4'b0000, 1'b1);
      @(negedge clk);
      bus.ack_toggle = ~bus.ack_toggle;
      @(posedge clk); #1;
      check_outs("post_reset_gap", 32'h1000_0007, 4'b0000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
